// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix-multiply job sequencer.
package matmul_pkg;

  localparam int N     = 10;
  localparam int DW    = 8;
  localparam int CW    = 20;
  localparam int AW    = 4;
  localparam int BEATS = N * N;

  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [6:0]    LAST_BEAT = 7'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ENG_START,
    ENG_WAIT,
    UNLOAD
  } state_t;

endpackage

// File: rtl/matmul_job_sequencer_c_readout_fifo.sv
// Two-entry FIFO that absorbs C read data while the host stalls the result stream.
module c_readout_fifo
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [CW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [CW-1:0] head
);

  logic [CW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Pointer and occupancy tracking; the controller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/matmul_job_sequencer.sv
// Job scheduler: loads A and B from the host stream, kicks the engine, then streams C back.
module matmul_job_sequencer
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_start,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          en_WriteMat_A,
  output logic [AW-1:0] rowAddr_A,
  output logic [AW-1:0] colAddr_A,
  output logic [DW-1:0] wdata_A,
  output logic          en_WriteMat_B,
  output logic [AW-1:0] rowAddr_B,
  output logic [AW-1:0] colAddr_B,
  output logic [DW-1:0] wdata_B,
  output logic          eng_start,
  input  logic          eng_done,
  output logic          en_ReadMat_C,
  output logic [AW-1:0] rowAddr_C,
  output logic [AW-1:0] colAddr_C,
  input  logic [CW-1:0] rdata_C,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_data
);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [6:0]    beat_cnt;
  logic          reads_done;
  logic          inflight;
  logic          done_q;
  logic [1:0]    fifo_count;
  logic [CW-1:0] fifo_head;
  logic          s_fire;
  logic          m_fire;
  logic          rd_issue;
  logic          at_last;
  logic          phase_change;

  assign at_last      = (row == LAST_IDX) && (col == LAST_IDX);
  assign s_fire       = s_valid && ((state == LOAD_A) || (state == LOAD_B));
  assign m_valid      = (fifo_count != 2'd0);
  assign m_data       = m_valid ? fifo_head : '0;
  assign m_fire       = m_valid && m_ready;
  assign phase_change = (state_next != state);

  // A read may only be issued if its data is guaranteed a FIFO slot when it returns.
  assign rd_issue = (state == UNLOAD) && !reads_done &&
                    (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, m_fire}));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Phase sequencing for one load-compute-unload job.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (cmd_start)         state_next = LOAD_A;
      LOAD_A:    if (s_fire && at_last) state_next = LOAD_B;
      LOAD_B:    if (s_fire && at_last) state_next = ENG_START;
      ENG_START:                        state_next = ENG_WAIT;
      ENG_WAIT:  if (eng_done)          state_next = UNLOAD;
      UNLOAD:    if (m_fire && (beat_cnt == LAST_BEAT)) state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Shared row-major address counter, advanced by load beats or issued C reads.
  always_ff @(posedge clk) begin
    if (reset || phase_change) begin
      row <= '0;
      col <= '0;
    end else if (s_fire || rd_issue) begin
      if (col == LAST_IDX) begin
        col <= '0;
        row <= (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Unload bookkeeping: read-in-flight flag, handshake count, and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight   <= 1'b0;
      reads_done <= 1'b0;
      beat_cnt   <= '0;
      done_q     <= 1'b0;
    end else begin
      inflight <= rd_issue;
      done_q   <= (state == UNLOAD) && (state_next == IDLE);
      if (phase_change) begin
        reads_done <= 1'b0;
        beat_cnt   <= '0;
      end else begin
        if (m_fire)              beat_cnt   <= beat_cnt + 7'd1;
        if (rd_issue && at_last) reads_done <= 1'b1;
      end
    end
  end

  // Memory-port and handshake outputs decoded from the current phase.
  always_comb begin
    busy          = (state != IDLE);
    done          = done_q;
    s_ready       = 1'b0;
    en_WriteMat_A = 1'b0;
    rowAddr_A     = '0;
    colAddr_A     = '0;
    wdata_A       = '0;
    en_WriteMat_B = 1'b0;
    rowAddr_B     = '0;
    colAddr_B     = '0;
    wdata_B       = '0;
    eng_start     = 1'b0;
    en_ReadMat_C  = 1'b0;
    rowAddr_C     = '0;
    colAddr_C     = '0;
    case (state)
      LOAD_A: begin
        s_ready       = 1'b1;
        en_WriteMat_A = s_valid;
        if (s_valid) begin
          rowAddr_A = row;
          colAddr_A = col;
          wdata_A   = s_data;
        end
      end
      LOAD_B: begin
        s_ready       = 1'b1;
        en_WriteMat_B = s_valid;
        if (s_valid) begin
          rowAddr_B = row;
          colAddr_B = col;
          wdata_B   = s_data;
        end
      end
      ENG_START: eng_start = 1'b1;
      UNLOAD: begin
        en_ReadMat_C = rd_issue;
        if (rd_issue) begin
          rowAddr_C = row;
          colAddr_C = col;
        end
      end
      default: ;
    endcase
  end

  c_readout_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (rdata_C),
    .pop       (m_fire),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Randomized scoreboard bench for matmul_job_sequencer with a behavioural engine and memories.
module tb_matmul_job_sequencer;
  import matmul_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic          busy, done;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          en_WriteMat_A, en_WriteMat_B;
  logic [AW-1:0] rowAddr_A, colAddr_A, rowAddr_B, colAddr_B;
  logic [DW-1:0] wdata_A, wdata_B;
  logic          eng_start;
  logic          eng_done;
  logic          en_ReadMat_C;
  logic [AW-1:0] rowAddr_C, colAddr_C;
  logic [CW-1:0] rdata_C = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] m_data;

  always #5 clk = ~clk;

  matmul_job_sequencer dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .en_WriteMat_A(en_WriteMat_A), .rowAddr_A(rowAddr_A), .colAddr_A(colAddr_A), .wdata_A(wdata_A),
    .en_WriteMat_B(en_WriteMat_B), .rowAddr_B(rowAddr_B), .colAddr_B(colAddr_B), .wdata_B(wdata_B),
    .eng_start(eng_start), .eng_done(eng_done),
    .en_ReadMat_C(en_ReadMat_C), .rowAddr_C(rowAddr_C), .colAddr_C(colAddr_C), .rdata_C(rdata_C),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus-side expectations shared with the monitor.
  int exp_a [BEATS];
  int exp_b [BEATS];
  int exp_q [$];

  // Behavioural memories and engine configuration.
  int mem_a [16][16];
  int mem_b [16][16];
  int mem_c [16][16];
  int m_ready_pct = 100;
  int eng_delay = 50;
  bit eng_held = 1'b0;

  // Monitor state.
  int wr_a_idx = 0, wr_b_idx = 0, rd_idx = 0, pop_cnt = 0;
  int eng_pulses = 0, done_pulses = 0;
  int es_cyc = -100000, done_cyc = 0;
  bit prev_stall = 1'b0, prev_es = 1'b0;
  logic [CW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C memory read port: data one cycle after the enable.
  always @(posedge clk) begin
    if (en_ReadMat_C) rdata_C <= CW'(mem_c[rowAddr_C][colAddr_C]);
  end

  // Engine completion model.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = eng_held || (cyc == es_cyc + eng_delay);
    end
  end

  // Host result-stream backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < m_ready_pct);
    end
  end

  // Monitor: memory writes, engine start, C reads and the result stream against the scoreboard.
  always @(negedge clk) begin
    int e;
    int outstanding;
    logic [AW-1:0] er, ec;
    if (reset) begin
      wr_a_idx = 0; wr_b_idx = 0; rd_idx = 0; pop_cnt = 0;
      prev_stall = 1'b0; prev_es = 1'b0;
    end else begin
      if ((s_valid && s_ready) || en_WriteMat_A || en_WriteMat_B)
        checkOutput(((en_WriteMat_A | en_WriteMat_B) == (s_valid && s_ready)) && !(en_WriteMat_A && en_WriteMat_B),
                    "write_vs_handshake", {en_WriteMat_A, en_WriteMat_B}, {1'b0, s_valid && s_ready});
      if (en_WriteMat_A) begin
        if (wr_a_idx >= BEATS) checkOutput(1'b0, "a_write_overflow", wr_a_idx, BEATS - 1);
        else begin
          er = AW'(wr_a_idx / N);
          ec = AW'(wr_a_idx % N);
          checkOutput(rowAddr_A == er && colAddr_A == ec && wdata_A == DW'(exp_a[wr_a_idx]), "a_write",
                      {rowAddr_A, colAddr_A, wdata_A}, {er, ec, DW'(exp_a[wr_a_idx])});
          mem_a[rowAddr_A][colAddr_A] = int'(wdata_A);
        end
        wr_a_idx++;
      end
      if (en_WriteMat_B) begin
        if (wr_b_idx >= BEATS) checkOutput(1'b0, "b_write_overflow", wr_b_idx, BEATS - 1);
        else begin
          er = AW'(wr_b_idx / N);
          ec = AW'(wr_b_idx % N);
          checkOutput(rowAddr_B == er && colAddr_B == ec && wdata_B == DW'(exp_b[wr_b_idx]), "b_write",
                      {rowAddr_B, colAddr_B, wdata_B}, {er, ec, DW'(exp_b[wr_b_idx])});
          mem_b[rowAddr_B][colAddr_B] = int'(wdata_B);
        end
        wr_b_idx++;
      end
      if (eng_start) begin
        checkOutput(!prev_es && wr_a_idx == BEATS && wr_b_idx == BEATS && busy, "eng_start_after_loads",
                    wr_a_idx * 1000 + wr_b_idx, BEATS * 1000 + BEATS);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            mem_c[i][j] = 0;
            for (int k = 0; k < N; k++) mem_c[i][j] += mem_a[i][k] * mem_b[k][j];
          end
        eng_pulses++;
        es_cyc = cyc;
        wr_a_idx = 0;
        wr_b_idx = 0;
      end
      prev_es = eng_start;
      if (en_ReadMat_C) begin
        er = AW'(rd_idx / N);
        ec = AW'(rd_idx % N);
        checkOutput(rd_idx < BEATS && rowAddr_C == er && colAddr_C == ec, "c_read_addr",
                    {rowAddr_C, colAddr_C}, {er, ec});
        outstanding = rd_idx + 1 - pop_cnt - int'(m_valid && m_ready);
        checkOutput(outstanding <= 2, "c_read_outstanding", outstanding, 2);
        rd_idx++;
      end
      if (prev_stall)
        checkOutput(m_valid && m_data == prev_data, "m_data_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) checkOutput(1'b0, "m_unexpected_beat", m_data, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput(m_data == CW'(e), "m_data", m_data, e);
        end
        pop_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (done) begin
        checkOutput(!busy && rd_idx == BEATS && pop_cnt == BEATS, "done_at_job_end",
                    pop_cnt, BEATS);
        done_pulses++;
        done_cyc = cyc;
        rd_idx = 0;
        pop_cnt = 0;
      end
    end
  end

  // Issues one job's command and operand stream; abort_beat >= 0 resets after that many beats.
  task automatic applyStimulus(input bit pattern, input int bubble_pct, input int abort_beat,
                               input bit start_in_load_b, output int cmd_cyc);
    int a [N][N];
    int b [N][N];
    int beat;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = pattern ? i + j : int'($urandom_range(0, 255));
        b[i][j] = pattern ? int'(i == j) : int'($urandom_range(0, 255));
        exp_a[i * N + j] = a[i][j];
        exp_b[i * N + j] = b[i][j];
      end
    if (abort_beat < 0)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          int sum = 0;
          for (int k = 0; k < N; k++) sum += a[i][k] * b[k][j];
          exp_q.push_back(sum);
        end
    cmd_start = 1'b1;
    cmd_cyc = cyc;
    step();
    cmd_start = 1'b0;
    checkOutput(busy && s_ready, "busy_after_cmd", {busy, s_ready}, 3);
    beat = 0;
    while (beat < 2 * BEATS) begin
      if (beat == abort_beat) begin
        s_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput(!busy && !s_ready && !en_WriteMat_A && !en_WriteMat_B && !eng_start && !en_ReadMat_C,
                    "reset_mid_load", {busy, s_ready, en_WriteMat_A, en_WriteMat_B}, 0);
        return;
      end
      s_valid = ($urandom_range(0, 99) >= bubble_pct);
      s_data = DW'(beat < BEATS ? exp_a[beat] : exp_b[beat - BEATS]);
      cmd_start = start_in_load_b && (beat == 150);
      step();
      if (s_valid) beat++;
    end
    s_valid = 1'b0;
    cmd_start = 1'b0;
  endtask

  task automatic run_job(input bit pattern, input int bubble_pct, input int mready_pct,
                         input int delay, input bit held, input bit start_mid);
    int cmd_cyc, d0, e0, t;
    m_ready_pct = mready_pct;
    eng_delay = delay;
    eng_held = held;
    d0 = done_pulses;
    e0 = eng_pulses;
    applyStimulus(pattern, bubble_pct, -1, start_mid, cmd_cyc);
    if (start_mid) begin
      t = 0;
      while (pop_cnt < 30 && done_pulses == d0 && t < 3000) begin step(); t++; end
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
    end
    t = 0;
    while (done_pulses == d0 && t < 3000) begin step(); t++; end
    checkOutput(t < 3000, "done_timeout", t, 3000);
    repeat (3) step();
    eng_held = 1'b0;
    checkOutput(done_pulses - d0 == 1 && eng_pulses - e0 == 1 && !busy && exp_q.size() == 0,
                "job_complete", (done_pulses - d0) * 10 + (eng_pulses - e0), 11);
    if (bubble_pct == 0 && mready_pct == 100) begin
      checkOutput(es_cyc - cmd_cyc == 201, "cmd_to_eng_start", es_cyc - cmd_cyc, 201);
      checkOutput(done_cyc - es_cyc == (held ? 2 : delay + 1) + 102, "eng_start_to_done",
                  done_cyc - es_cyc, (held ? 2 : delay + 1) + 102);
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cc;
    reset = 1'b1;
    cmd_start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) step();
    checkOutput({busy, done, s_ready, eng_start, en_WriteMat_A, rowAddr_A, colAddr_A, wdata_A,
                 en_WriteMat_B, rowAddr_B, colAddr_B, wdata_B, en_ReadMat_C, rowAddr_C, colAddr_C,
                 m_valid, m_data} == '0, "reset_outputs",
                $countones({busy, done, s_ready, eng_start, en_WriteMat_A, rowAddr_A, colAddr_A, wdata_A,
                            en_WriteMat_B, rowAddr_B, colAddr_B, wdata_B, en_ReadMat_C, rowAddr_C,
                            colAddr_C, m_valid, m_data}), 0);
    reset = 1'b0;
    step();
    $display("[TB] job 1: pattern operands, no stalls");
    run_job(1'b1, 0, 100, 50, 1'b0, 1'b0);
    $display("[TB] job 2: input bubbles");
    run_job(1'b0, 50, 100, int'($urandom_range(5, 30)), 1'b0, 1'b0);
    $display("[TB] job 3: output backpressure");
    run_job(1'b0, 0, 30, 10, 1'b0, 1'b0);
    $display("[TB] job 4: cmd_start while busy");
    run_job(1'b0, 20, 70, 15, 1'b0, 1'b1);
    $display("[TB] job 5: reset during A load");
    applyStimulus(1'b0, 0, 37, 1'b0, cc);
    repeat (2) step();
    run_job(1'b0, 0, 100, 8, 1'b0, 1'b0);
    $display("[TB] job 6: eng_done held high");
    run_job(1'b0, 0, 100, 0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
